// File: rtl/object_motion_pkg.sv
// Shared types and constants for the object motion engine.
// The helper turns a pair of opposing key requests into a signed step direction.
package object_motion_pkg;

  typedef logic [3:0] edge_code;

  localparam int LEFT_EDGE   = 3;
  localparam int TOP_EDGE    = 2;
  localparam int RIGHT_EDGE  = 1;
  localparam int BOTTOM_EDGE = 0;

  localparam int DEFAULT_COORD_W = 11;
  typedef logic signed [DEFAULT_COORD_W-1:0] coordinate;

  localparam int MOTION_MANUAL = 0;
  localparam int MOTION_BOUNCE = 1;

  // Both keys or neither cancel out to no direction.
  function automatic logic signed [1:0] direction(input logic toward_low, input logic toward_high);
    if (toward_high && !toward_low) begin
      return 2'sb01;
    end
    if (toward_low && !toward_high) begin
      return 2'sb11;
    end
    return 2'sb00;
  endfunction

endpackage

// File: rtl/object_motion_axis_velocity.sv
// One axis of object velocity: manual accel/decel ramps or bounce reflection.
// The low edge is left/top, the high edge is right/bottom.
module axis_velocity
  import object_motion_pkg::*;
#(
  parameter int MODE      = MOTION_MANUAL,
  parameter int W         = 17,
  parameter int MAX_SPEED = 256,
  parameter int ACCEL     = 64,
  parameter int DECEL     = 64,
  parameter int INIT_V    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [1:0]   d,
  input  logic                low_edge_flag,
  input  logic                high_edge_flag,
  input  logic                step,
  input  logic                load,
  output logic signed [W-1:0] vel
);

  localparam logic signed [W:0]   MAX_EXT   = (W+1)'(MAX_SPEED);
  localparam logic signed [W:0]   ACCEL_EXT = (W+1)'(ACCEL);
  localparam logic signed [W-1:0] DECEL_V   = W'(DECEL);
  localparam logic signed [W-1:0] START_V   = (MODE == MOTION_BOUNCE) ? W'(INIT_V) : '0;

  logic                going_low;
  logic                going_high;
  logic                want_low;
  logic                want_high;
  logic signed [W:0]   vel_ext;
  logic signed [W:0]   sum_ext;
  logic signed [W-1:0] next_vel;

  always_comb begin
    going_low  = vel[W-1];
    going_high = !vel[W-1] && (vel != '0);
    want_low   = (d == 2'sb11);
    want_high  = (d == 2'sb01);
    vel_ext    = {vel[W-1], vel};
    sum_ext    = want_high ? (vel_ext + ACCEL_EXT) : (vel_ext - ACCEL_EXT);
    next_vel   = vel;

    if (MODE == MOTION_BOUNCE) begin
      if ((going_low && low_edge_flag) || (going_high && high_edge_flag)) begin
        next_vel = -vel;
      end
    end else if ((low_edge_flag && (want_low || going_low)) ||
                 (high_edge_flag && (want_high || going_high))) begin
      next_vel = '0;
    end else if ((want_high && going_low) || (want_low && going_high)) begin
      next_vel = '0;
    end else if (want_high || want_low) begin
      // Saturate one bit wider so the sum cannot wrap before clamping.
      if (sum_ext > MAX_EXT) begin
        next_vel = MAX_EXT[W-1:0];
      end else if (sum_ext < -MAX_EXT) begin
        next_vel = (-MAX_EXT);
      end else begin
        next_vel = sum_ext[W-1:0];
      end
    end else if (going_high && (vel > DECEL_V)) begin
      next_vel = vel - DECEL_V;
    end else if (going_low && (vel < -DECEL_V)) begin
      next_vel = vel + DECEL_V;
    end else begin
      next_vel = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || load) begin
      vel <= START_V;
    end else if (step) begin
      vel <= next_vel;
    end
  end

endmodule

// File: rtl/object_motion.sv
// Fixed-point position/velocity engine for one on-screen object, stepped once per frame.
// Border hits are latched between frame steps and cleared on every frame pulse.
module object_motion
  import object_motion_pkg::*;
#(
  parameter int MODE      = MOTION_MANUAL,
  parameter int FRAC_BITS = 6,
  parameter int COORD_W   = 11,
  parameter int INIT_X    = 0,
  parameter int INIT_Y    = 0,
  parameter int MAX_SPEED = 256,
  parameter int ACCEL     = 64,
  parameter int DECEL     = 64,
  parameter int INIT_VX   = 128,
  parameter int INIT_VY   = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                startOfFrame,
  input  logic                                enable,
  input  logic                                move_left,
  input  logic                                move_right,
  input  logic                                move_up,
  input  logic                                move_down,
  input  logic                                border_collision,
  input  edge_code                            HitEdgeCode,
  input  logic                                load,
  input  logic signed [COORD_W-1:0]           load_x,
  input  logic signed [COORD_W-1:0]           load_y,
  output logic signed [COORD_W-1:0]           topLeftX,
  output logic signed [COORD_W-1:0]           topLeftY,
  output logic signed [COORD_W+FRAC_BITS-1:0] velX,
  output logic signed [COORD_W+FRAC_BITS-1:0] velY,
  output logic                                moving
);

  localparam int W = COORD_W + FRAC_BITS;
  localparam logic [COORD_W-1:0]  INIT_PX = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0]  INIT_PY = COORD_W'(INIT_Y);
  localparam logic signed [W-1:0] INIT_FX = {INIT_PX, {FRAC_BITS{1'b0}}};
  localparam logic signed [W-1:0] INIT_FY = {INIT_PY, {FRAC_BITS{1'b0}}};

  edge_code            flags;
  edge_code            eff_flags;
  logic                step;
  logic signed [1:0]   dir_x;
  logic signed [1:0]   dir_y;
  logic signed [W-1:0] pos_x;
  logic signed [W-1:0] pos_y;

  always_comb begin
    eff_flags = flags | (border_collision ? HitEdgeCode : '0);
    step      = startOfFrame && enable && !load;
    dir_x     = (MODE == MOTION_BOUNCE) ? 2'sb00 : direction(move_left, move_right);
    dir_y     = (MODE == MOTION_BOUNCE) ? 2'sb00 : direction(move_up, move_down);
  end

  // Any frame pulse drops the latched hits, even when the object is frozen.
  always_ff @(posedge clk) begin
    if (reset || load || startOfFrame) begin
      flags <= '0;
    end else if (border_collision) begin
      flags <= flags | HitEdgeCode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x <= INIT_FX;
      pos_y <= INIT_FY;
    end else if (load) begin
      pos_x <= {load_x, {FRAC_BITS{1'b0}}};
      pos_y <= {load_y, {FRAC_BITS{1'b0}}};
    end else if (step) begin
      pos_x <= pos_x + velX;
      pos_y <= pos_y + velY;
    end
  end

  axis_velocity #(
    .MODE      (MODE),
    .W         (W),
    .MAX_SPEED (MAX_SPEED),
    .ACCEL     (ACCEL),
    .DECEL     (DECEL),
    .INIT_V    (INIT_VX)
  ) u_axis_x (
    .clk            (clk),
    .reset          (reset),
    .d              (dir_x),
    .low_edge_flag  (eff_flags[LEFT_EDGE]),
    .high_edge_flag (eff_flags[RIGHT_EDGE]),
    .step           (step),
    .load           (load),
    .vel            (velX)
  );

  axis_velocity #(
    .MODE      (MODE),
    .W         (W),
    .MAX_SPEED (MAX_SPEED),
    .ACCEL     (ACCEL),
    .DECEL     (DECEL),
    .INIT_V    (INIT_VY)
  ) u_axis_y (
    .clk            (clk),
    .reset          (reset),
    .d              (dir_y),
    .low_edge_flag  (eff_flags[TOP_EDGE]),
    .high_edge_flag (eff_flags[BOTTOM_EDGE]),
    .step           (step),
    .load           (load),
    .vel            (velY)
  );

  // Upper bits of a two's complement fixed-point value give the floored pixel.
  always_comb begin
    topLeftX = pos_x[W-1:FRAC_BITS];
    topLeftY = pos_y[W-1:FRAC_BITS];
    moving   = (velX != '0) || (velY != '0);
  end

endmodule

// File: tb/tb_object_motion.sv
// Drives a manual and a bounce instance with shared stimulus and compares both
// against an integer reference model of the motion rules every cycle.
module tb_object_motion;

  localparam int MAN_X = 100, MAN_Y = 50, BNC_X = 300, BNC_Y = 200;
  localparam int VX0 = 128, VY0 = 64, MAXV = 256, ACC = 64, DEC = 64, FIX = 64;

  logic clk = 1'b0;
  logic reset, startOfFrame, enable;
  logic move_left, move_right, move_up, move_down;
  logic border_collision, load;
  logic [3:0] HitEdgeCode;
  logic signed [10:0] load_x, load_y;

  logic signed [10:0] manX, manY, bncX, bncY;
  logic signed [16:0] manVx, manVy, bncVx, bncVy;
  logic manMoving, bncMoving;

  int checks = 0;
  int errors = 0;
  int mPos[2][2];
  int mVel[2][2];
  bit [3:0] mFlags[2];
  int savedPx;

  always #5 clk = ~clk;

  object_motion #(.MODE(0), .INIT_X(MAN_X), .INIT_Y(MAN_Y)) u_man (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
    .border_collision(border_collision), .HitEdgeCode(HitEdgeCode), .load(load),
    .load_x(load_x), .load_y(load_y), .topLeftX(manX), .topLeftY(manY),
    .velX(manVx), .velY(manVy), .moving(manMoving));

  object_motion #(.MODE(1), .INIT_X(BNC_X), .INIT_Y(BNC_Y), .INIT_VX(VX0), .INIT_VY(VY0)) u_bnc (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
    .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
    .border_collision(border_collision), .HitEdgeCode(HitEdgeCode), .load(load),
    .load_x(load_x), .load_y(load_y), .topLeftX(bncX), .topLeftY(bncY),
    .velX(bncVx), .velY(bncVy), .moving(bncMoving));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int wrapFix(input int p);
    int r;
    r = p % 131072;
    if (r < 0) r += 131072;
    if (r >= 65536) r -= 131072;
    return r;
  endfunction

  function automatic int pixelOf(input int p);
    return (p >= 0) ? p / FIX : -((-p + FIX - 1) / FIX);
  endfunction

  function automatic int nextVel(input int mode, input int v, input int d, input bit lowHit, input bit highHit);
    int s;
    int nv;
    if (mode == 1) return ((v < 0 && lowHit) || (v > 0 && highHit)) ? -v : v;
    if ((lowHit && (d < 0 || v < 0)) || (highHit && (d > 0 || v > 0))) return 0;
    s = (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    if (d != 0 && s == -d) return 0;
    if (d != 0) begin
      nv = v + d * ACC;
      if (nv > MAXV) nv = MAXV;
      if (nv < -MAXV) nv = -MAXV;
      return nv;
    end
    if (v > DEC) return v - DEC;
    if (v < -DEC) return v + DEC;
    return 0;
  endfunction

  // Advances the model by the effect of the upcoming clock edge.
  task automatic modelCycle();
    bit [3:0] eff;
    int dx, dy;
    dx = int'(move_right) - int'(move_left);
    dy = int'(move_down) - int'(move_up);
    for (int m = 0; m < 2; m++) begin
      eff = mFlags[m] | (border_collision ? HitEdgeCode : 4'b0000);
      if (reset) begin
        mPos[m][0] = ((m == 0) ? MAN_X : BNC_X) * FIX;
        mPos[m][1] = ((m == 0) ? MAN_Y : BNC_Y) * FIX;
        mVel[m][0] = (m == 0) ? 0 : VX0;
        mVel[m][1] = (m == 0) ? 0 : VY0;
        mFlags[m] = 4'b0000;
      end else if (load) begin
        mPos[m][0] = int'(load_x) * FIX;
        mPos[m][1] = int'(load_y) * FIX;
        mVel[m][0] = (m == 0) ? 0 : VX0;
        mVel[m][1] = (m == 0) ? 0 : VY0;
        mFlags[m] = 4'b0000;
      end else if (startOfFrame && enable) begin
        mPos[m][0] = wrapFix(mPos[m][0] + mVel[m][0]);
        mPos[m][1] = wrapFix(mPos[m][1] + mVel[m][1]);
        mVel[m][0] = nextVel(m, mVel[m][0], dx, eff[3], eff[1]);
        mVel[m][1] = nextVel(m, mVel[m][1], dy, eff[2], eff[0]);
        mFlags[m] = 4'b0000;
      end else if (startOfFrame) begin
        mFlags[m] = 4'b0000;
      end else if (border_collision) begin
        mFlags[m] = mFlags[m] | HitEdgeCode;
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("man_x", int'(manX), pixelOf(mPos[0][0]));
    checkOutput("man_y", int'(manY), pixelOf(mPos[0][1]));
    checkOutput("man_vx", int'(manVx), mVel[0][0]);
    checkOutput("man_vy", int'(manVy), mVel[0][1]);
    checkOutput("man_moving", int'(manMoving), int'(mVel[0][0] != 0 || mVel[0][1] != 0));
    checkOutput("bnc_x", int'(bncX), pixelOf(mPos[1][0]));
    checkOutput("bnc_y", int'(bncY), pixelOf(mPos[1][1]));
    checkOutput("bnc_vx", int'(bncVx), mVel[1][0]);
    checkOutput("bnc_vy", int'(bncVy), mVel[1][1]);
    checkOutput("bnc_moving", int'(bncMoving), int'(mVel[1][0] != 0 || mVel[1][1] != 0));
  endtask

  // Inputs are set at a falling edge; the model and DUT both see them at the next rising edge.
  task automatic applyStimulus();
    modelCycle();
    @(negedge clk);
    checkModel();
  endtask

  task automatic runFrame(input bit left, input bit right);
    move_left = left;
    move_right = right;
    startOfFrame = 1'b0;
    applyStimulus();
    startOfFrame = 1'b1;
    applyStimulus();
    startOfFrame = 1'b0;
  endtask

  task automatic hitMidFrame(input logic [3:0] code);
    startOfFrame = 1'b0;
    border_collision = 1'b1;
    HitEdgeCode = code;
    applyStimulus();
    border_collision = 1'b0;
    HitEdgeCode = 4'b0000;
  endtask

  initial begin
    int rampV[5] = '{64, 128, 192, 256, 256};
    int rampX[5] = '{100, 101, 103, 106, 110};
    int relV[5] = '{192, 128, 64, 0, 0};

    reset = 1'b1; startOfFrame = 1'b0; enable = 1'b1;
    move_left = 1'b0; move_right = 1'b0; move_up = 1'b0; move_down = 1'b0;
    border_collision = 1'b0; HitEdgeCode = 4'b0000; load = 1'b0;
    load_x = '0; load_y = '0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("rst_man_x", int'(manX), MAN_X);
    checkOutput("rst_man_vx", int'(manVx), 0);
    checkOutput("rst_man_moving", int'(manMoving), 0);
    checkOutput("rst_bnc_vx", int'(bncVx), VX0);
    checkOutput("rst_bnc_vy", int'(bncVy), VY0);

    for (int i = 0; i < 5; i++) begin
      runFrame(1'b0, 1'b1);
      checkOutput("ramp_vx", int'(manVx), rampV[i]);
      checkOutput("ramp_x", int'(manX), rampX[i]);
    end
    for (int i = 0; i < 5; i++) begin
      runFrame(1'b0, 1'b0);
      checkOutput("release_vx", int'(manVx), relV[i]);
    end
    runFrame(1'b0, 1'b1);
    runFrame(1'b0, 1'b1);
    runFrame(1'b1, 1'b1);
    checkOutput("both_keys_vx1", int'(manVx), 64);
    runFrame(1'b1, 1'b1);
    checkOutput("both_keys_vx2", int'(manVx), 0);

    for (int i = 0; i < 4; i++) runFrame(1'b0, 1'b1);
    hitMidFrame(4'b0010);
    savedPx = pixelOf(mPos[0][0]);
    runFrame(1'b0, 1'b1);
    checkOutput("wall_vx", int'(manVx), 0);
    checkOutput("wall_x", int'(manX), savedPx + 4);
    runFrame(1'b0, 1'b1);
    checkOutput("wall_clear_vx", int'(manVx), 64);

    move_right = 1'b0;
    startOfFrame = 1'b1; load = 1'b1; load_x = -11'sd5; load_y = 11'sd20;
    applyStimulus();
    startOfFrame = 1'b0; load = 1'b0;
    checkOutput("load_man_x", int'(manX), -5);
    checkOutput("load_bnc_x", int'(bncX), -5);
    checkOutput("load_man_vx", int'(manVx), 0);
    checkOutput("load_bnc_vx", int'(bncVx), VX0);

    load = 1'b1; load_x = '0;
    applyStimulus();
    load = 1'b0;
    runFrame(1'b1, 1'b0);
    runFrame(1'b0, 1'b0);
    checkOutput("neg_one_px", int'(manX), -1);

    border_collision = 1'b1; HitEdgeCode = 4'b0010; startOfFrame = 1'b1;
    applyStimulus();
    border_collision = 1'b0; HitEdgeCode = 4'b0000; startOfFrame = 1'b0;
    checkOutput("bnc_same_cycle", int'(bncVx), -VX0);
    hitMidFrame(4'b1000);
    runFrame(1'b0, 1'b0);
    checkOutput("bnc_left_reflect", int'(bncVx), VX0);
    hitMidFrame(4'b1000);
    runFrame(1'b0, 1'b0);
    checkOutput("bnc_left_ignored", int'(bncVx), VX0);
    checkOutput("bnc_vy_kept", int'(bncVy), VY0);

    runFrame(1'b0, 1'b1);
    runFrame(1'b0, 1'b1);
    savedPx = pixelOf(mPos[0][0]);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hitMidFrame(4'b0010);
      runFrame(1'b0, 1'b1);
      checkOutput("frozen_vx", int'(manVx), 128);
      checkOutput("frozen_x", int'(manX), savedPx);
    end
    enable = 1'b1;
    runFrame(1'b0, 1'b1);
    checkOutput("stale_flags_vx", int'(manVx), 192);

    hitMidFrame(4'b0010);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midrst_x", int'(manX), MAN_X);
    checkOutput("midrst_vx", int'(manVx), 0);
    checkOutput("midrst_bnc_x", int'(bncX), BNC_X);
    runFrame(1'b0, 1'b1);
    checkOutput("midrst_flags_vx", int'(manVx), 64);

    for (int i = 0; i < 800; i++) begin
      startOfFrame = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 7) != 0);
      move_left = 1'($urandom_range(0, 1));
      move_right = 1'($urandom_range(0, 1));
      move_up = 1'($urandom_range(0, 1));
      move_down = 1'($urandom_range(0, 1));
      border_collision = ($urandom_range(0, 3) == 0);
      HitEdgeCode = 4'($urandom_range(0, 15));
      load = ($urandom_range(0, 40) == 0);
      load_x = 11'($urandom_range(0, 2047));
      load_y = 11'($urandom_range(0, 2047));
      reset = ($urandom_range(0, 150) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
